// File: rtl/iobuffer_fifo.sv
// iobuffer_fifo
//
// Single-clock synchronous FIFO for the I/O buffer path. It sits between the
// bus-engine core and the host-side transfer logic and absorbs rate mismatch
// in either direction. Storage is an inferred dual-port array with a
// registered read port.
//
// Parameters
//   WIDTH     data word width in bits (1..32)
//   DEPTH     number of entries, power of two (4..4096)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   flush         synchronous clear of pointers, count and error flags
//   wr_en / din   write request and data
//   rd_en         read request
//   dout          registered read data, holds until the next accepted read
//   dout_valid    one-cycle pulse when dout carries a newly read word
//   count         occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty
//                 decodes of the count register
//   overflow      sticky: a write was rejected since last reset/flush
//   underflow     sticky: a read was rejected since last reset/flush
module iobuffer_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  localparam int unsigned ABITS   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [ABITS:0]   count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  // Thresholds sized to the count register so every compare is width-matched.
  localparam logic [ABITS:0] DepthCnt = DEPTH[ABITS:0];
  localparam logic [ABITS:0] AfCnt    = AF_LEVEL[ABITS:0];
  localparam logic [ABITS:0] AeCnt    = AE_LEVEL[ABITS:0];

  // Storage
  logic [WIDTH-1:0] mem [DEPTH];

  // State
  logic [ABITS-1:0] wptr_q, wptr_d;
  logic [ABITS-1:0] rptr_q, rptr_d;
  logic [ABITS:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Handshake decode
  logic full_s, empty_s;
  logic rd_accept, wr_accept;

  assign full_s  = (count_q == DepthCnt);
  assign empty_s = (count_q == '0);

  // Flush wins over both requests, so it masks the accepts directly; this also
  // keeps the memory untouched and dout holding during a flush cycle.
  // A write into a full FIFO is still taken when a read frees the slot in the
  // same cycle; the memory then returns the old word at rptr (== wptr).
  always_comb begin
    rd_accept = rd_en && !empty_s && !flush;
    wr_accept = wr_en && (!full_s || rd_accept) && !flush;
  end

  // Next-state logic
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + ABITS'(1);
      end
      if (rd_accept) begin
        rptr_d       = rptr_q + ABITS'(1);
        dout_d       = mem[rptr_q];
        dout_valid_d = 1'b1;
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + (ABITS+1)'(1);
        2'b01:   count_d = count_q - (ABITS+1)'(1);
        default: count_d = count_q;
      endcase

      if (wr_en && !wr_accept) begin
        overflow_d = 1'b1;
      end
      if (rd_en && !rd_accept) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Memory write port; no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wptr_q] <= din;
    end
  end

  // Control and read-data registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Outputs: registers and decodes of count_q only.
  always_comb begin
    dout         = dout_q;
    dout_valid   = dout_valid_q;
    count        = count_q;
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_iobuffer_fifo.sv
// Testbench for iobuffer_fifo with DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_iobuffer_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;

  iobuffer_fifo #(
    .WIDTH   (8),
    .DEPTH   (8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         fl;
    bit         wr;
    bit         rd;
    logic [7:0] d;
    int         cnt;
    bit         dv;
    logic [7:0] dq;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [5:0] eflags(input int c, input bit o, input bit u);
    return {c == 8, c == 0, c >= 6, c <= 2, o, u};
  endfunction

  function automatic logic [5:0] aflags();
    return {full, empty, almost_full, almost_empty, overflow, underflow};
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input bit fl, input bit wr, input bit rd, input logic [7:0] d);
    flush = fl;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clock);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic add(input bit fl, input bit wr, input bit rd, input logic [7:0] d,
                     input int cnt, input bit dv, input logic [7:0] dq, input bit ovf,
                     input bit unf);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.d = d;
    v.cnt = cnt; v.dv = dv; v.dq = dq; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         sent;
    int         got;
    int         cyc;
    bit         w, r, ra, wa;
    logic [7:0] d;

    // Table: fill, overflow, drain, underflow, write+read on empty, flush.
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(i), i, 0, 8'h00, 0, 0);
    add(0, 1, 0, 8'hFF, 8, 0, 8'h00, 1, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 8'h00, 8 - k, 1, 8'(k), 1, 0);
    add(0, 0, 0, 8'h00, 0, 0, 8'h08, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 8'h08, 1, 1);
    add(0, 1, 1, 8'h5A, 1, 0, 8'h08, 1, 1);
    add(0, 0, 1, 8'h00, 0, 1, 8'h5A, 1, 1);
    add(1, 0, 0, 8'h00, 0, 0, 8'h5A, 0, 0);

    do_reset();

    // Reset state
    chk("reset count", 32'(count), 32'd0);
    chk("reset dout", 32'(dout), 32'h00);
    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    chk("reset flags", 32'(aflags()), 32'(eflags(0, 0, 0)));

    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].dv));
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].dq));
      chk($sformatf("vec%0d flags", i), 32'(aflags()),
          32'(eflags(vecs[i].cnt, vecs[i].ovf, vecs[i].unf)));
    end

    // Full FIFO with simultaneous write and read.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i));
    chk("full before wr+rd", 32'(full), 32'd1);
    step(0, 1, 1, 8'hAA);
    chk("full wr+rd count", 32'(count), 32'd8);
    chk("full wr+rd dout", 32'(dout), 32'h10);
    chk("full wr+rd dout_valid", 32'(dout_valid), 32'd1);
    chk("full wr+rd overflow", 32'(overflow), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, 8'h00);
      chk($sformatf("full drain %0d dout", k), 32'(dout),
          (k == 8) ? 32'hAA : 32'(8'h10 + k));
    end
    chk("full drain count", 32'(count), 32'd0);

    // Flush at count 5 with overflow set and a write in the same cycle.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h40 + i));
    step(0, 1, 0, 8'h99);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
    chk("pre-flush count", 32'(count), 32'd5);
    chk("pre-flush overflow", 32'(overflow), 32'd1);
    step(1, 1, 0, 8'h77);
    chk("flush count", 32'(count), 32'd0);
    chk("flush flags", 32'(aflags()), 32'(eflags(0, 0, 0)));
    chk("flush dout hold", 32'(dout), 32'h42);
    chk("flush dout_valid", 32'(dout_valid), 32'd0);
    step(0, 1, 0, 8'h33);
    step(0, 0, 1, 8'h00);
    chk("post-flush read", 32'(dout), 32'h33);
    chk("post-flush count", 32'(count), 32'd0);

    // Random stream of 100 words against a queue model.
    do_reset();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
      w  = (sent < 100) && ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5);
      d  = 8'(sent + 1);
      ra = r && (q.size() > 0);
      wa = w && ((q.size() < 8) || ra);
      step(0, w, r, d);
      if (ra) begin
        exp_d = q.pop_front();
        got++;
        chk($sformatf("stream %0d dout_valid", cyc), 32'(dout_valid), 32'd1);
        chk($sformatf("stream %0d dout", cyc), 32'(dout), 32'(exp_d));
      end else begin
        chk($sformatf("stream %0d dout_valid", cyc), 32'(dout_valid), 32'd0);
      end
      if (wa) begin
        q.push_back(d);
        sent++;
      end
      chk($sformatf("stream %0d count", cyc), 32'(count), 32'(q.size()));
      chk($sformatf("stream %0d almost_full", cyc), 32'(almost_full), 32'(q.size() >= 6));
      chk($sformatf("stream %0d almost_empty", cyc), 32'(almost_empty), 32'(q.size() <= 2));
      cyc++;
    end
    chk("stream words received", 32'(got), 32'd100);

    // Asynchronous reset while a read result is on dout.
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 0, 1, 8'h00);
    chk("pre-reset dout", 32'(dout), 32'h11);
    chk("pre-reset dout_valid", 32'(dout_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset dout", 32'(dout), 32'h00);
    chk("async reset dout_valid", 32'(dout_valid), 32'd0);
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset flags", 32'(aflags()), 32'(eflags(0, 0, 0)));
    #1;
    reset = 1'b0;
    step(0, 0, 0, 8'h00);
    chk("after reset count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
